divide_remainder: RTL

Sequential signed divider: the inverse of the multiply-add primitive. It decomposes a dividend N into a quotient Q and remainder R such that N = Q*D + R. It uses truncation toward zero, matching Verilog `/` and `%`. It resolves one quotient bit per enabled clock and sits beside the multiply-add units in the linear-algebra layer, serving normalisation and back-substitution paths that have no single-cycle divide.

---
 rtl/divide_remainder.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/divide_remainder.sv
// divide_remainder: sequential signed divider (restoring, one quotient bit
// per enabled clock). Produces Q and R with N = Q*D + R, truncating toward
// zero like Verilog '/' and '%'. Flags divide-by-zero and the single
// unrepresentable quotient (most negative N divided by -1).
module divide_remainder #(
   parameter int IN_N_WIDTH = 20,
   parameter int IN_D_WIDTH = 10
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         enable,
   input  logic                         start,
   input  logic signed [IN_N_WIDTH-1:0] N,
   input  logic signed [IN_D_WIDTH-1:0] D,
   output logic signed [IN_N_WIDTH-1:0] Q,
   output logic signed [IN_D_WIDTH-1:0] R,
   output logic                         busy,
   output logic                         done,
   output logic                         dz,
   output logic                         ovf
);

   localparam int CW = $clog2(IN_N_WIDTH + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(IN_N_WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

   state_t                  r_state;
   logic [CW-1:0]           r_cnt;
   // Dividend magnitude; quotient bits shift in from the LSB as dividend
   // bits shift out of the MSB, so this ends CALC holding |Q|.
   logic [IN_N_WIDTH-1:0]   r_dvd;
   logic [IN_D_WIDTH-1:0]   r_dvs;
   // Remainder after each step is < |D| <= 2^(IN_D_WIDTH-1), so IN_D_WIDTH
   // bits hold it; the shifted trial window below is one bit wider.
   logic [IN_D_WIDTH-1:0]   r_rem;
   logic                    r_sign_q;
   logic                    r_sign_r;
   logic                    r_dz_pend;
   logic                    r_ovf_pend;
   logic [IN_N_WIDTH-1:0]   r_q;
   logic [IN_D_WIDTH-1:0]   r_r;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_dz;
   logic                    r_ovf;

   logic [IN_N_WIDTH-1:0]   w_abs_n;
   logic [IN_D_WIDTH-1:0]   w_abs_d;
   logic                    w_ovf_in;
   logic [IN_D_WIDTH:0]     w_rem_sh;
   logic                    w_ge;
   logic [IN_D_WIDTH-1:0]   w_diff;
   logic [IN_D_WIDTH-1:0]   w_rem_nx;
   logic [IN_N_WIDTH-1:0]   w_q_fix;
   logic [IN_D_WIDTH-1:0]   w_r_fix;

   // Operand magnitudes; the most negative value maps to 2^(W-1) unsigned.
   assign w_abs_n  = N[IN_N_WIDTH-1] ? (~N + 1'b1) : N;
   assign w_abs_d  = D[IN_D_WIDTH-1] ? (~D + 1'b1) : D;
   assign w_ovf_in = N[IN_N_WIDTH-1] && !(|N[IN_N_WIDTH-2:0]) && (&D);

   // One restoring step. When the trial succeeds the true difference is
   // below |D|, so the modulo-2^IN_D_WIDTH subtraction is exact.
   assign w_rem_sh = {r_rem, r_dvd[IN_N_WIDTH-1]};
   assign w_ge     = (w_rem_sh >= {1'b0, r_dvs});
   assign w_diff   = w_rem_sh[IN_D_WIDTH-1:0] - r_dvs;
   assign w_rem_nx = w_ge ? w_diff : w_rem_sh[IN_D_WIDTH-1:0];

   // Sign restoration; |N|=2^(W-1), D=-1 wraps naturally to -2^(W-1).
   assign w_q_fix  = r_sign_q ? (~r_dvd + 1'b1) : r_dvd;
   assign w_r_fix  = r_sign_r ? (~r_rem + 1'b1) : r_rem;

   assign Q    = r_q;
   assign R    = r_r;
   assign busy = r_busy;
   assign done = r_done;
   assign dz   = r_dz;
   assign ovf  = r_ovf;

   // Control FSM with datapath: accept in IDLE, iterate in CALC, sign-fix in FIX.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_dvd      <= '0;
         r_dvs      <= '0;
         r_rem      <= '0;
         r_sign_q   <= 1'b0;
         r_sign_r   <= 1'b0;
         r_dz_pend  <= 1'b0;
         r_ovf_pend <= 1'b0;
         r_q        <= '0;
         r_r        <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_dz       <= 1'b0;
         r_ovf      <= 1'b0;
      end else if (enable) begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_dvd      <= w_abs_n;
                  r_dvs      <= w_abs_d;
                  r_sign_q   <= N[IN_N_WIDTH-1] ^ D[IN_D_WIDTH-1];
                  r_sign_r   <= N[IN_N_WIDTH-1];
                  r_dz_pend  <= (D == '0);
                  r_ovf_pend <= w_ovf_in;
                  r_rem      <= '0;
                  r_cnt      <= CNT_INIT;
                  r_busy     <= 1'b1;
                  r_state    <= S_CALC;
               end
            end
            S_CALC: begin
               r_rem <= w_rem_nx;
               r_dvd <= {r_dvd[IN_N_WIDTH-2:0], w_ge};
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == CNT_LAST) begin
                  r_state <= S_FIX;
               end
            end
            S_FIX: begin
               // Divide-by-zero ran the full iteration count on garbage; drop it.
               if (r_dz_pend) begin
                  r_q <= '0;
                  r_r <= '0;
               end else begin
                  r_q <= w_q_fix;
                  r_r <= w_r_fix;
               end
               r_dz    <= r_dz_pend;
               r_ovf   <= r_ovf_pend;
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
